parity_frame_chk: RTL and testbench
===================================

PARITY_FRAME_CHK -- requirements
Module: parity_frame_chk

Interface
REQ-001 SHALL provide parameter W, default 4: data word width in bits, W >= 1.
REQ-002 SHALL provide parameter N, default 4: words per frame, N >= 1.
REQ-003 SHALL provide parameter CNTW, default 8: width of the word-error counter.
REQ-004 SHALL have a single clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
REQ-005 SHALL provide these input ports:
- mode  in  1  0 = even parity, 1 = odd parity; sampled on a frame's first accepted word
- clr_cnt  in  1  synchronous clear of err_cnt
- in_valid  in  1  word offered
- in_data  in  W  data word
- in_par  in  1  received parity bit for in_data
REQ-006 SHALL provide these output ports:
- in_ready  out  1  word can be accepted
- word_valid  out  1  one-cycle strobe, per-word result valid
- word_par  out  1  generated parity bit for the word
- word_err  out  1  in_par mismatched word_par
- frame_valid  out  1  one-cycle strobe, frame result valid
- frame_par  out  1  generated parity over all N*W frame data bits
- frame_err  out  1  at least one word_err in the frame
- err_cnt  out  CNTW  saturating count of word errors

Function
REQ-007 SHALL accept a word on a rising edge where in_valid & in_ready = 1; no other input word is consumed.
REQ-008 SHALL compute generated parity so that data plus parity bit has an even count of ones in even mode (p = XOR-reduce of data) and an odd count in odd mode (p = XNOR-reduce of data).
REQ-009 SHALL register word_valid, word_par and word_err one cycle after acceptance, with word_err = (in_par != p); word_valid = 0 in all other cycles.
REQ-010 SHALL implement an FSM with states IDLE, ACC and FLUSH:
- IDLE: frame counter 0
- IDLE -> ACC on acceptance when N > 1
- IDLE -> FLUSH on acceptance when N = 1
- ACC -> FLUSH on acceptance of word N-1
- FLUSH -> IDLE unconditionally after one cycle
REQ-011 SHALL drive in_ready = 1 in IDLE and ACC, 0 in FLUSH, and 0 while rst = 1; a continuous stream therefore takes N+1 cycles per frame.
REQ-012 SHALL latch mode in the cycle the first word of a frame is accepted and use the latched value for the whole frame; mode changes mid-frame are ignored.
REQ-013 SHALL pulse frame_valid for exactly one cycle in FLUSH, coincident with word_valid of the last word, with frame_par = latched-mode parity over all frame bits and frame_err = OR of the frame's word_err values, including the last word's.
REQ-014 SHALL hold frame_par and frame_err stable until the next frame_valid pulse.
REQ-015 SHALL increment err_cnt by 1 per word_err and saturate at 2^CNTW-1 with no wrap.
REQ-016 SHALL give clr_cnt priority: when clr_cnt coincides with an error increment, err_cnt = 0 on the next cycle.
REQ-017 SHALL contain no combinational path from in_data or in_par to any output; only in_ready is combinational, from state and rst.

Reset
REQ-018 SHALL, on rst = 1 at a rising edge, return the FSM to IDLE and clear the frame counter, latched mode, the frame parity/error accumulators, all registered outputs and err_cnt to 0.
REQ-019 SHALL discard a partial frame when reset arrives mid-frame, with no frame_valid issued for it; the first word accepted after reset starts a new frame.
REQ-020 SHALL raise in_ready in the first cycle after rst deasserts.

Verification (W=4, N=4, CNTW=8 unless stated)
REQ-021 SHALL cover even mode, words 0x0,0x3,0x5,0x7 with in_par 0,0,0,1 back-to-back -> word_err 0 on all four; frame_valid with frame_par=1, frame_err=0; err_cnt=0.
REQ-022 SHALL cover odd mode, single frame 0xF,0xF,0xF,0xF with in_par 0,1,1,1 -> first word_par=1, word_err=1, the others 0; frame_par=1 (16 ones, odd mode); frame_err=1; err_cnt=1.
REQ-023 SHALL cover continuous in_valid=1 -> in_ready low only in the cycle after each fourth acceptance; 8 words complete in 10 cycles with 2 frame_valid pulses.
REQ-024 SHALL cover reset after 2 accepted words, then 4 fresh words -> no frame_valid for the partial frame; exactly one frame_valid after the fourth fresh word.
REQ-025 SHALL cover mode toggled 0->1 after the first word of a frame -> parity for all four words and frame_par computed in even mode.
REQ-026 SHALL cover CNTW=2, six erroneous words with clr_cnt asserted on the sixth -> err_cnt reads 1,2,3,3,3 and then 0.

Source files
------------

// File: rtl/parity_frame_chk.sv
// Per-word and per-frame parity checker with a saturating word-error count.
// Frames are N words; a one-cycle flush after the last word closes each frame.
module parity_frame_chk #(
    parameter int W    = 4,
    parameter int N    = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic            clr_cnt,
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    input  logic            in_par,
    output logic            in_ready,
    output logic            word_valid,
    output logic            word_par,
    output logic            word_err,
    output logic            frame_valid,
    output logic            frame_par,
    output logic            frame_err,
    output logic [CNTW-1:0] err_cnt
);

    localparam int FW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FLUSH
    } state_t;

    state_t state, state_nxt;

    logic [FW-1:0] fcnt, fcnt_nxt;
    logic          mode_q;
    logic          fx_q;
    logic          fe_q;
    logic          acc;
    logic          last;
    logic          mode_eff;
    logic          p;
    logic          err;
    logic          fx_nxt;
    logic          fe_nxt;

    assign in_ready = !rst && (state != FLUSH);
    assign acc      = in_valid && in_ready;
    assign last     = (fcnt == FW'(N - 1));

    // The first word of a frame uses live mode; later words use the latch.
    assign mode_eff = (state == IDLE) ? mode : mode_q;
    assign p        = (^in_data) ^ mode_eff;
    assign err      = in_par ^ p;
    assign fx_nxt   = ((state == IDLE) ? 1'b0 : fx_q) ^ (^in_data);
    assign fe_nxt   = ((state == IDLE) ? 1'b0 : fe_q) | err;

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        unique case (state)
            IDLE, ACC: begin
                if (acc) begin
                    if (last) begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = '0;
                    end else begin
                        state_nxt = ACC;
                        fcnt_nxt  = fcnt + FW'(1);
                    end
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                fcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fcnt        <= '0;
            mode_q      <= 1'b0;
            fx_q        <= 1'b0;
            fe_q        <= 1'b0;
            word_valid  <= 1'b0;
            word_par    <= 1'b0;
            word_err    <= 1'b0;
            frame_valid <= 1'b0;
            frame_par   <= 1'b0;
            frame_err   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            fcnt        <= fcnt_nxt;
            word_valid  <= acc;
            frame_valid <= acc && last;
            if (acc) begin
                word_par <= p;
                word_err <= err;
                fx_q     <= fx_nxt;
                fe_q     <= fe_nxt;
                if (state == IDLE) begin
                    mode_q <= mode;
                end
            end
            if (acc && last) begin
                frame_par <= fx_nxt ^ mode_eff;
                frame_err <= fe_nxt;
            end
            // Clear wins over a coincident increment.
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (acc && err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_chk.sv
// Bench for parity_frame_chk: frame-level model plus directed scenarios.
// Two instances share stimulus to exercise 8-bit and 2-bit counters.
module tb_parity_frame_chk;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       clr_cnt;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_par;

    logic       rdy8, wv8, wp8, we8, fv8, fp8, fe8;
    logic [7:0] cnt8;
    logic       rdy2, wv2, wp2, we2, fv2, fp2, fe2;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    parity_frame_chk #(.W(4), .N(N), .CNTW(8)) dut8 (
        .clk(clk), .rst(rst), .mode(mode), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_data(in_data), .in_par(in_par),
        .in_ready(rdy8), .word_valid(wv8), .word_par(wp8),
        .word_err(we8), .frame_valid(fv8), .frame_par(fp8),
        .frame_err(fe8), .err_cnt(cnt8)
    );

    parity_frame_chk #(.W(4), .N(N), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .mode(mode), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_data(in_data), .in_par(in_par),
        .in_ready(rdy2), .word_valid(wv2), .word_par(wp2),
        .word_err(we2), .frame_valid(fv2), .frame_par(fp2),
        .frame_err(fe2), .err_cnt(cnt2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model state: frame position, flush cycle, frame mode and bit tally.
    bit m_flush = 0;
    int m_k     = 0;
    bit m_mode  = 0;
    int m_ones  = 0;
    bit m_ferr  = 0;
    bit e_wv = 0, e_wp = 0, e_we = 0, e_fv = 0, e_fp = 0, e_fe = 0;
    int e_c8 = 0, e_c2 = 0;

    logic wq_par[$];
    logic wq_err[$];
    int   wq_c2[$];
    int   wq_c8[$];
    logic fq_par[$];
    logic fq_err[$];
    int   fv_count = 0;

    always @(negedge clk) begin : compare
        bit acc_m;
        int pw;
        chk("in_ready8", rdy8, 32'(!rst && !m_flush));
        chk("in_ready2", rdy2, 32'(!rst && !m_flush));
        chk("word_valid8", wv8, 32'(e_wv));
        chk("word_valid2", wv2, 32'(e_wv));
        chk("word_par8", wp8, 32'(e_wp));
        chk("word_par2", wp2, 32'(e_wp));
        chk("word_err8", we8, 32'(e_we));
        chk("word_err2", we2, 32'(e_we));
        chk("frame_valid8", fv8, 32'(e_fv));
        chk("frame_valid2", fv2, 32'(e_fv));
        chk("frame_par8", fp8, 32'(e_fp));
        chk("frame_par2", fp2, 32'(e_fp));
        chk("frame_err8", fe8, 32'(e_fe));
        chk("frame_err2", fe2, 32'(e_fe));
        chk("err_cnt8", cnt8, 32'(e_c8));
        chk("err_cnt2", cnt2, 32'(e_c2));
        if (wv8 === 1'b1) begin
            wq_par.push_back(wp8);
            wq_err.push_back(we8);
            wq_c2.push_back(int'(cnt2));
            wq_c8.push_back(int'(cnt8));
        end
        if (fv8 === 1'b1) begin
            fq_par.push_back(fp8);
            fq_err.push_back(fe8);
            fv_count++;
        end
        if (rst) begin
            m_flush = 0; m_k = 0; m_mode = 0; m_ones = 0; m_ferr = 0;
            e_wv = 0; e_wp = 0; e_we = 0; e_fv = 0; e_fp = 0; e_fe = 0;
            e_c8 = 0; e_c2 = 0;
        end else begin
            acc_m   = in_valid && !m_flush;
            e_wv    = 0;
            e_fv    = 0;
            m_flush = 0;
            if (acc_m) begin
                if (m_k == 0) begin
                    m_mode = mode;
                    m_ones = 0;
                    m_ferr = 0;
                end
                pw     = ($countones(in_data) + int'(m_mode)) % 2;
                e_wv   = 1;
                e_wp   = pw[0];
                e_we   = (in_par != pw[0]);
                m_ones = m_ones + $countones(in_data);
                m_ferr = m_ferr | e_we;
                m_k++;
                if (m_k == N) begin
                    e_fv    = 1;
                    e_fp    = ((m_ones + int'(m_mode)) % 2) == 1;
                    e_fe    = m_ferr;
                    m_flush = 1;
                    m_k     = 0;
                end
            end
            if (clr_cnt) begin
                e_c8 = 0;
                e_c2 = 0;
            end else if (acc_m && e_we) begin
                if (e_c8 < 255) e_c8++;
                if (e_c2 < 3) e_c2++;
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] d, input logic p,
                        input logic m, input logic c);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_par   = p;
        mode     = m;
        clr_cnt  = c;
        t = 0;
        @(negedge clk);
        while (!rdy8 && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (t >= 20) chk("send_timeout", rdy8, 1);
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
    endtask

    task automatic clear_logs();
        wq_par.delete();
        wq_err.delete();
        wq_c2.delete();
        wq_c8.delete();
        fq_par.delete();
        fq_err.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ex_par[6];
        int ex_err[6];
        int ex_c[6];
        int r[10];
        int nrdy;
        int fv0;

        rst      = 1'b1;
        mode     = 1'b0;
        clr_cnt  = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        in_par   = 1'b0;

        // Reset state and ready rising right after release.
        idle(2);
        chk("rst_ready", rdy8, 0);
        chk("rst_cnt", cnt8, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", rdy8, 1);
        @(posedge clk);
        #1;

        // Even mode, clean frame.
        clear_logs();
        send(4'h0, 0, 0, 0);
        send(4'h3, 0, 0, 0);
        send(4'h5, 0, 0, 0);
        send(4'h7, 1, 0, 0);
        idle(3);
        ex_par = '{0, 0, 0, 1, 0, 0};
        chk("even_words", wq_par.size(), 4);
        if (wq_par.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("even_wpar", wq_par[i], ex_par[i]);
                chk("even_werr", wq_err[i], 0);
            end
            chk("even_cnt", wq_c8[3], 0);
        end
        chk("even_frames", fq_par.size(), 1);
        if (fq_par.size() == 1) begin
            chk("even_fpar", fq_par[0], 1);
            chk("even_ferr", fq_err[0], 0);
        end

        // Odd mode, one bad word.
        clear_logs();
        send(4'hF, 0, 1, 0);
        send(4'hF, 1, 1, 0);
        send(4'hF, 1, 1, 0);
        send(4'hF, 1, 1, 0);
        idle(3);
        ex_err = '{1, 0, 0, 0, 0, 0};
        chk("odd_words", wq_par.size(), 4);
        if (wq_par.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("odd_wpar", wq_par[i], 1);
                chk("odd_werr", wq_err[i], ex_err[i]);
            end
            chk("odd_cnt", wq_c8[3], 1);
        end
        chk("odd_frames", fq_par.size(), 1);
        if (fq_par.size() == 1) begin
            chk("odd_fpar", fq_par[0], 1);
            chk("odd_ferr", fq_err[0], 1);
        end

        // Continuous stream: 8 words in 10 cycles.
        clear_logs();
        fv0      = fv_count;
        nrdy     = 0;
        in_valid = 1'b1;
        mode     = 1'b0;
        in_par   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_data = 4'(i);
            @(negedge clk);
            r[i] = int'(rdy8);
            nrdy += r[i];
            @(posedge clk);
            #1;
        end
        idle(1);
        chk("stream_ready_cycles", nrdy, 8);
        chk("stream_ready_4", r[4], 0);
        chk("stream_ready_9", r[9], 0);
        chk("stream_words", wq_par.size(), 8);
        chk("stream_frames", fv_count - fv0, 2);

        // Reset mid-frame discards the partial frame.
        clear_logs();
        send(4'h1, 1, 0, 0);
        send(4'h2, 1, 0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send(4'h3, 0, 0, 0);
        send(4'h4, 1, 0, 0);
        send(4'h5, 0, 0, 0);
        chk("partial_no_frame", fq_par.size(), 0);
        send(4'h6, 0, 0, 0);
        idle(3);
        chk("partial_one_frame", fq_par.size(), 1);
        chk("partial_cnt_cleared", cnt8, 0);

        // Mode flips after the first word; frame stays even.
        clear_logs();
        send(4'h1, 1, 0, 0);
        send(4'h3, 0, 1, 0);
        send(4'h7, 1, 1, 0);
        send(4'h0, 0, 1, 0);
        idle(3);
        ex_par = '{1, 0, 1, 0, 0, 0};
        chk("mode_words", wq_par.size(), 4);
        if (wq_par.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("mode_wpar", wq_par[i], ex_par[i]);
                chk("mode_werr", wq_err[i], 0);
            end
        end
        chk("mode_frames", fq_par.size(), 1);
        if (fq_par.size() == 1) begin
            chk("mode_fpar", fq_par[0], 0);
            chk("mode_ferr", fq_err[0], 0);
        end

        // Saturation of the narrow counter and clear priority.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        clear_logs();
        for (int i = 0; i < 5; i++) send(4'h0, 1, 0, 0);
        send(4'h0, 1, 0, 1);
        idle(2);
        ex_c   = '{1, 2, 3, 3, 3, 0};
        ex_par = '{1, 2, 3, 4, 5, 0};
        chk("sat_words", wq_c2.size(), 6);
        if (wq_c2.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("sat_cnt2", wq_c2[i], ex_c[i]);
                chk("sat_cnt8", wq_c8[i], ex_par[i]);
            end
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
